// File: rtl/counter_pkg.sv
// Shared definitions for the counter arbiter: FSM state encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_pkg;

    // Default number of requesters sharing the counter.
    localparam int DEF_NUM_REQ = 4;
    // Default width of load value, run length and counter output.
    localparam int DEF_WIDTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: picks the first set request at or above ptr, wrapping past N-1.
// Latency: combinational, same cycle.
// Backpressure: none; grant is all-zero when no request is set.
// Ports: req (request vector), ptr (search start index),
//        grant (one-hot), grant_idx (binary index of the granted bit).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  ptr,
    output logic [N-1:0]          grant,
    output logic [$clog2(N)-1:0]  grant_idx
);

    localparam int IW = $clog2(N);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        // Walk the N positions starting at ptr; the first hit wins.
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/counter_arb.sv
// Arbitrates NUM_REQ requesters onto one external counter: load start, count len cycles, report.
// Latency: accept at cycle 0, LOAD 1, RUN 2..len+1, DONE len+2 (+1 per LOAD stall on all-ones count).
// Backpressure: req_ready only in IDLE (one job at a time); done_valid is a pulse with no backpressure.
// Ports: clk/reset; req_valid/req_start/req_len in, req_ready out (one-hot);
//        cnt_load/cnt_enable/cnt_data drive the counter, cnt_count is its value;
//        done_valid/done_id/done_count/done_wrap report each finished job.
module counter_arb
    import counter_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int IDATA_WIDTH  = DEF_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][IDATA_WIDTH-1:0]  req_start,
    input  logic [NUM_REQ-1:0][IDATA_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 cnt_load,
    output logic                                 cnt_enable,
    output logic [IDATA_WIDTH-1:0]               cnt_data,
    input  logic [OUTPUT_WIDTH-1:0]              cnt_count,
    output logic                                 done_valid,
    output logic [$clog2(NUM_REQ)-1:0]           done_id,
    output logic [OUTPUT_WIDTH-1:0]              done_count,
    output logic                                 done_wrap
);

    localparam int IDW = $clog2(NUM_REQ);

    if (OUTPUT_WIDTH != IDATA_WIDTH) begin : g_width_check
        $error("counter_arb: OUTPUT_WIDTH must equal IDATA_WIDTH");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_num_req_check
        $error("counter_arb: NUM_REQ must be in 2..16");
    end

    state_t                 state;
    logic [IDW-1:0]         rr_ptr;
    logic [IDW-1:0]         grant_idx;
    logic [NUM_REQ-1:0]     grant;
    logic [IDW-1:0]         cap_id;
    logic [IDATA_WIDTH-1:0] cap_start;
    logic [IDATA_WIDTH-1:0] cap_len;
    logic [IDATA_WIDTH-1:0] remain;
    logic                   wrap_seen;
    logic                   cnt_at_max;
    logic                   run_wrap;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Acceptance is only offered in IDLE, and never while reset is asserted.
    assign req_ready  = (state == ST_IDLE && !reset) ? grant : '0;

    // An all-ones counter clears on the next edge regardless of load.
    assign cnt_at_max = (cnt_count == '1);
    assign run_wrap   = wrap_seen | cnt_at_max;

    // The final count is only known while DONE is active, so it is taken live.
    assign done_count = done_valid ? cnt_count : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            cap_id     <= '0;
            cap_start  <= '0;
            cap_len    <= '0;
            remain     <= '0;
            wrap_seen  <= 1'b0;
            cnt_load   <= 1'b0;
            cnt_enable <= 1'b0;
            cnt_data   <= '0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_wrap  <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            done_id    <= '0;
            done_wrap  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req_ready) begin
                        cap_start <= req_start[grant_idx];
                        cap_len   <= req_len[grant_idx];
                        cap_id    <= grant_idx;
                        rr_ptr    <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        wrap_seen <= 1'b0;
                        remain    <= '0;
                        cnt_load  <= 1'b1;
                        cnt_data  <= req_start[grant_idx];
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cnt_at_max) begin
                        // Clear wins over load this cycle; repeat the load.
                        cnt_load <= 1'b1;
                        cnt_data <= cap_start;
                    end else if (cap_len == '0) begin
                        cnt_load   <= 1'b0;
                        cnt_data   <= '0;
                        done_valid <= 1'b1;
                        done_id    <= cap_id;
                        done_wrap  <= 1'b0;
                        state      <= ST_DONE;
                    end else begin
                        cnt_load   <= 1'b0;
                        cnt_data   <= '0;
                        cnt_enable <= 1'b1;
                        remain     <= cap_len;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    wrap_seen <= run_wrap;
                    remain    <= remain - 1'b1;
                    if (remain == IDATA_WIDTH'(1)) begin
                        cnt_enable <= 1'b0;
                        done_valid <= 1'b1;
                        done_id    <= cap_id;
                        done_wrap  <= run_wrap;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/counter_arb.md
COUNTER_ARB -- requirements
Module: counter_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one counter; range 2..16.
REQ-002 Parameter IDATA_WIDTH, default 16: width of the counter load value and of the run length.
REQ-003 Parameter OUTPUT_WIDTH, default 16: counter output width; SHALL equal IDATA_WIDTH (elaboration-time check).
REQ-004 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port req_valid  in  NUM_REQ  per-requester request; held with its payload until accepted.
REQ-007 Port req_start  in  NUM_REQ x IDATA_WIDTH  per-requester counter start value.
REQ-008 Port req_len  in  NUM_REQ x IDATA_WIDTH  per-requester number of enabled count cycles.
REQ-009 Port req_ready  out  NUM_REQ  one-hot acceptance pulse.
REQ-010 Port cnt_load  out  1  drives the shared counter's load input.
REQ-011 Port cnt_enable  out  1  drives the shared counter's enable input.
REQ-012 Port cnt_data  out  IDATA_WIDTH  drives the shared counter's data_in.
REQ-013 Port cnt_count  in  OUTPUT_WIDTH  shared counter's count value.
REQ-014 Port done_valid  out  1  single-cycle completion pulse; no backpressure.
REQ-015 Port done_id  out  clog2(NUM_REQ)  index of the completed requester.
REQ-016 Port done_count  out  OUTPUT_WIDTH  final counter value.
REQ-017 Port done_wrap  out  1  the counter passed through all-ones during the run.

Function
REQ-018 FSM states: IDLE, LOAD, RUN, DONE.
REQ-019 Arbitration:
- In IDLE with any req_valid set, a round-robin arbiter grants exactly one requester, searching from pointer rr_ptr upward with wrap.
- req_ready[grant] is 1 in that same cycle; a transfer occurs when req_valid and req_ready are both 1.
- At the transfer the block captures start, len and id; rr_ptr becomes (grant+1) mod NUM_REQ.
- The FSM moves to LOAD.
REQ-020 req_ready SHALL be all-zero in every state other than IDLE.
REQ-021 LOAD: cnt_load=1, cnt_enable=0, cnt_data=captured start.
- If cnt_count is all-ones, the counter's clear takes priority over load; the FSM SHALL stay in LOAD one more cycle.
- Otherwise the FSM moves to RUN, or to DONE when len=0.
REQ-022 RUN: cnt_enable=1, cnt_load=0 for exactly len cycles, tracked by an internal down-counter; after the last enabled cycle the FSM moves to DONE.
REQ-023 Arithmetic: count wraps modulo 2^OUTPUT_WIDTH; done_wrap=1 if cnt_count equalled all-ones in any RUN cycle of this job.
REQ-024 DONE lasts one cycle:
- done_valid=1, done_id=captured id, done_count=cnt_count.
- Next state is IDLE.
REQ-025 Latency, accept at cycle 0:
- LOAD in cycle 1; RUN in cycles 2..len+1; DONE in cycle len+2 with done_count=(start+len) mod 2^W.
- The next acceptance is possible in cycle len+3.
- Each LOAD stall from REQ-021 adds 1 cycle.
REQ-026 cnt_load and cnt_enable SHALL never both be 1; cnt_data SHALL be 0 outside LOAD.
REQ-027 In IDLE, cnt_load=0 and cnt_enable=0; the counter holds its value.
REQ-028 done_id, done_count and done_wrap SHALL be 0 whenever done_valid=0.

Reset
REQ-029 On reset:
- FSM goes to IDLE; rr_ptr=0.
- Captured payload, down-counter and wrap flag clear to 0.
- All outputs are 0 in the cycle after reset is sampled.
REQ-030 Reset in any state SHALL abandon the job with no done_valid.
REQ-031 Reset SHALL take priority over a simultaneous transfer; no acceptance occurs while reset=1.

Structure
REQ-032 Shared package counter_pkg SHALL hold the FSM state enum and the default width and NUM_REQ constants.
REQ-033 Round-robin grant logic SHALL be a separate sub-module rr_arbiter: inputs req and ptr; outputs one-hot grant and grant index.
REQ-034 The shared counter is instantiated outside counter_arb; counter_arb only drives its load, enable and data_in.

Verification (bench pairs counter_arb with the team counter, both 16-bit)
REQ-035 Requester 1 alone, start=10, len=5 -> req_ready[1] pulses at cycle 0; done_valid in cycle 7 with done_id=1, done_count=15, done_wrap=0.
REQ-036 All 4 requesters valid continuously, rr_ptr=0 -> grant order 0,1,2,3,0; no requester is granted twice before every other valid requester has been granted.
REQ-037 start=0xFFFE, len=3 -> done_count=0x0001, done_wrap=1.
REQ-038 Counter preset to 0xFFFF at entry to LOAD, start=5, len=0 -> LOAD lasts 2 cycles; done_count=5 with done_valid one cycle later; cnt_load and cnt_enable never both 1.
REQ-039 reset asserted in the 3rd RUN cycle of a len=8 job -> no done_valid; all outputs 0 the next cycle; rr_ptr=0; a new request is accepted on the first cycle after reset deasserts.
